// File: rtl/mux_l2_pkg.sv
// Shared definitions for the two-lane to one-lane byte multiplexer:
// output FSM encoding, the idle byte value and the pair-word field layout.
package mux_l2_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND0 = 2'd1,
    SEND1 = 2'd2
  } state_t;

  localparam logic [7:0] IDLE_BYTE = 8'h00;

  // Pair word, LSB first: data0, valid0, data1, valid1.
  function automatic int pair_w(input int dw);
    return 2 * dw + 2;
  endfunction

  function automatic int v0_pos(input int dw);
    return dw;
  endfunction

  function automatic int d1_lsb(input int dw);
    return dw + 1;
  endfunction

  function automatic int v1_pos(input int dw);
    return 2 * dw + 1;
  endfunction

endpackage

// File: rtl/pair_fifo.sv
// Synchronous show-ahead FIFO holding byte pairs; full/empty are registered
// so downstream readiness never depends on same-cycle push/pop activity.
module pair_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 18
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_n;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    count_n = count;
    if (do_push && !do_pop) begin
      count_n = count + CW'(1);
    end else if (do_pop && !do_push) begin
      count_n = count - CW'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      count <= count_n;
      full  <= (count_n == CW'(DEPTH));
      empty <= (count_n == '0);
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
    end
  end

  // NOTE: the storage array is deliberately not reset; occupancy is tracked by
  // count, so stale entries are never observed and the array maps to plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/mux_l2.sv
// Two-lane to one-lane byte multiplexer: samples a byte pair every other cycle
// and streams lane0 then lane1. Optional macro MUXL2_SKIP_IDLE_EN drops invalid slots.
module mux_l2
  import mux_l2_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = 8
) (
  input  logic          cclk,
  input  logic          reset,
  input  logic          valid_in0,
  input  logic [DW-1:0] data_in0,
  input  logic          valid_in1,
  input  logic [DW-1:0] data_in1,
  output logic          in_ready,
  input  logic          out_ready,
  output logic          valid_out,
  output logic [DW-1:0] data_out,
  output logic          phase,
  output logic          overflow
);

  localparam int PW = pair_w(DW);
  localparam int V0 = v0_pos(DW);
  localparam int D1 = d1_lsb(DW);
  localparam int V1 = v1_pos(DW);
  localparam logic [DW-1:0] IDLE_W = DW'(IDLE_BYTE);

`ifdef MUXL2_SKIP_IDLE_EN
  localparam bit SKIP_IDLE = 1'b1;
`else
  localparam bit SKIP_IDLE = 1'b0;
`endif

  logic [PW-1:0] head;
  logic          head_v0;
  logic [DW-1:0] head_d0;
  logic          head_v1;
  logic [DW-1:0] head_d1;
  logic          full;
  logic          empty;
  logic          sample;
  logic          push;
  logic          pop;

  state_t        state;
  state_t        state_n;
  state_t        load_state;
  logic          load_valid;
  logic [DW-1:0] load_data;
  logic          advance;
  logic          hold_v1;
  logic          hold_v1_n;
  logic [DW-1:0] hold_d1;
  logic [DW-1:0] hold_d1_n;
  logic          valid_n;
  logic [DW-1:0] data_n;

  assign head_d0 = head[DW-1:0];
  assign head_v0 = head[V0];
  assign head_d1 = head[D1 +: DW];
  assign head_v1 = head[V1];

  // Full is judged on the registered count: a pop on the sample edge does not
  // make room for the pair being offered.
  assign sample   = !phase && (valid_in0 || valid_in1);
  assign push     = sample && !full;
  assign in_ready = !full;

  pair_fifo #(
    .DEPTH (DEPTH),
    .W     (PW)
  ) u_fifo (
    .clk   (cclk),
    .rst   (reset),
    .push  (push),
    .pop   (pop),
    .din   ({valid_in1, data_in1, valid_in0, data_in0}),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge cclk or posedge reset) begin
    if (reset) begin
      phase    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      phase <= ~phase;
      if (sample && full) overflow <= 1'b1;
    end
  end

  // First slot of the FIFO head pair when it is popped.
  always_comb begin
    load_state = SEND0;
    load_valid = head_v0;
    load_data  = head_v0 ? head_d0 : IDLE_W;
    if (SKIP_IDLE && !head_v0) begin
      load_state = SEND1;
      load_valid = head_v1;
      load_data  = head_v1 ? head_d1 : IDLE_W;
    end
  end

  always_comb begin
    state_n   = state;
    hold_v1_n = hold_v1;
    hold_d1_n = hold_d1;
    valid_n   = valid_out;
    data_n    = data_out;
    pop       = 1'b0;
    advance   = 1'b0;

    case (state)
      IDLE: advance = 1'b1;
      SEND0: begin
        if (out_ready) begin
          if (SKIP_IDLE && !hold_v1) begin
            advance = 1'b1;
          end else begin
            state_n = SEND1;
            valid_n = hold_v1;
            data_n  = hold_v1 ? hold_d1 : IDLE_W;
          end
        end
      end
      SEND1: advance = out_ready;
      default: begin
        state_n = IDLE;
        valid_n = 1'b0;
        data_n  = IDLE_W;
      end
    endcase

    // Current pair finished (or none active): fetch the next one or go idle.
    if (advance) begin
      if (!empty) begin
        pop       = 1'b1;
        state_n   = load_state;
        valid_n   = load_valid;
        data_n    = load_data;
        hold_v1_n = head_v1;
        hold_d1_n = head_d1;
      end else begin
        state_n = IDLE;
        valid_n = 1'b0;
        data_n  = IDLE_W;
      end
    end
  end

  always_ff @(posedge cclk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      hold_v1   <= 1'b0;
      hold_d1   <= '0;
      valid_out <= 1'b0;
      data_out  <= IDLE_W;
    end else begin
      state     <= state_n;
      hold_v1   <= hold_v1_n;
      hold_d1   <= hold_d1_n;
      valid_out <= valid_n;
      data_out  <= data_n;
    end
  end

endmodule

// File: tb/tb_mux_l2.sv
// Self-checking bench for mux_l2: directed scenarios plus random traffic,
// compared each cycle against a queue-based slot-stream model.
module tb_mux_l2;

  localparam int DEPTH = 4;
  localparam int DW    = 8;

  logic          cclk = 1'b0;
  logic          reset = 1'b1;
  logic          valid_in0 = 1'b0;
  logic [DW-1:0] data_in0 = '0;
  logic          valid_in1 = 1'b0;
  logic [DW-1:0] data_in1 = '0;
  logic          out_ready = 1'b1;
  logic          in_ready;
  logic          valid_out;
  logic [DW-1:0] data_out;
  logic          phase;
  logic          overflow;

  int checks = 0;
  int errors = 0;

  always #5 cclk = ~cclk;

  mux_l2 #(.DEPTH(DEPTH), .DW(DW)) dut (
    .cclk      (cclk),
    .reset     (reset),
    .valid_in0 (valid_in0),
    .data_in0  (data_in0),
    .valid_in1 (valid_in1),
    .data_in1  (data_in1),
    .in_ready  (in_ready),
    .out_ready (out_ready),
    .valid_out (valid_out),
    .data_out  (data_out),
    .phase     (phase),
    .overflow  (overflow)
  );

  typedef struct packed {
    logic          v1;
    logic [DW-1:0] d1;
    logic          v0;
    logic [DW-1:0] d0;
  } pair_t;

  typedef struct packed {
    logic          v;
    logic [DW-1:0] d;
  } slot_t;

  // Model: queued pairs, remaining output slots of the current pair, and
  // the slot currently presented on the outputs.
  pair_t         fifo_q[$];
  slot_t         rem_q[$];
  logic          m_busy;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_phase;
  logic          m_over;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic slot_t mk_slot(input logic v, input logic [DW-1:0] d);
    slot_t s;
    s.v = v;
    s.d = v ? d : '0;
    return s;
  endfunction

  task automatic model_reset();
    fifo_q.delete();
    rem_q.delete();
    m_busy  = 1'b0;
    m_valid = 1'b0;
    m_data  = '0;
    m_phase = 1'b0;
    m_over  = 1'b0;
  endtask

  task automatic load_pair(input pair_t p);
    rem_q.delete();
`ifdef MUXL2_SKIP_IDLE_EN
    if (p.v0) rem_q.push_back(mk_slot(1'b1, p.d0));
    if (p.v1) rem_q.push_back(mk_slot(1'b1, p.d1));
`else
    rem_q.push_back(mk_slot(p.v0, p.d0));
    rem_q.push_back(mk_slot(p.v1, p.d1));
`endif
  endtask

  task automatic present_next();
    slot_t s;
    s       = rem_q.pop_front();
    m_busy  = 1'b1;
    m_valid = s.v;
    m_data  = s.d;
  endtask

  // One rising edge of the model, using the inputs currently driven.
  task automatic model_edge();
    int    n_pre;
    pair_t p;
    n_pre = fifo_q.size();
    if (!m_busy || out_ready) begin
      if (rem_q.size() > 0) begin
        present_next();
      end else if (n_pre > 0) begin
        p = fifo_q.pop_front();
        load_pair(p);
        present_next();
      end else begin
        m_busy  = 1'b0;
        m_valid = 1'b0;
        m_data  = '0;
      end
    end
    if (!m_phase && (valid_in0 || valid_in1)) begin
      if (n_pre == DEPTH) begin
        m_over = 1'b1;
      end else begin
        p.v0 = valid_in0; p.d0 = data_in0;
        p.v1 = valid_in1; p.d1 = data_in1;
        fifo_q.push_back(p);
      end
    end
    m_phase = ~m_phase;
  endtask

  task automatic check_all();
    check("valid_out", valid_out, m_valid);
    check("data_out", data_out, m_data);
    check("in_ready", in_ready, fifo_q.size() < DEPTH);
    check("overflow", overflow, m_over);
    check("phase", phase, m_phase);
  endtask

  task automatic cyc(input logic v0, input logic [DW-1:0] d0,
                     input logic v1, input logic [DW-1:0] d1, input logic rdy);
    valid_in0 = v0; data_in0 = d0;
    valid_in1 = v1; data_in1 = d1;
    out_ready = rdy;
    @(posedge cclk);
    model_edge();
    @(negedge cclk);
    check_all();
  endtask

  // Waits for a sample edge (driving junk on the ignored phase) then offers a pair.
  task automatic offer(input logic v0, input logic [DW-1:0] d0,
                       input logic v1, input logic [DW-1:0] d1, input logic rdy);
    if (m_phase) cyc(1'b1, 8'hEE, 1'b1, 8'hDD, rdy);
    cyc(v0, d0, v1, d1, rdy);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, '0, 1'b1);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "simulation did not terminate");
  end

  initial begin
    logic [DW-1:0] b0;
    logic [DW-1:0] b1;

    // Reset state
    model_reset();
    @(negedge cclk);
    check("rst_valid_out", valid_out, 1'b0);
    check("rst_data_out", data_out, 8'h00);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_overflow", overflow, 1'b0);
    check("rst_phase", phase, 1'b0);
    reset = 1'b0;

    // Single pair latency: lane0 after E+1, lane1 after E+2, then idle
    offer(1'b1, 8'hA5, 1'b1, 8'h3C, 1'b1);
    idle(1);
    check("lat_e1_valid", valid_out, 1'b1);
    check("lat_e1_data", data_out, 8'hA5);
    idle(1);
    check("lat_e2_data", data_out, 8'h3C);
    idle(1);
    check("lat_e3_valid", valid_out, 1'b0);

    // Continuous pairs at full input rate
    for (int k = 0; k < 3; k++) begin
      b0 = 8'(8'h11 + 8'h22 * k);
      b1 = 8'(8'h22 + 8'h22 * k);
      offer(1'b1, b0, 1'b1, b1, 1'b1);
      check("stream_in_ready", in_ready, 1'b1);
    end
    idle(4);

    // Pair with only lane1 valid
    offer(1'b0, 8'h00, 1'b1, 8'h7E, 1'b1);
    idle(1);
`ifdef MUXL2_SKIP_IDLE_EN
    check("lane1_only_data", data_out, 8'h7E);
    check("lane1_only_valid", valid_out, 1'b1);
    idle(3);
`else
    check("lane1_only_slot0_valid", valid_out, 1'b0);
    check("lane1_only_slot0_data", data_out, 8'h00);
    idle(1);
    check("lane1_only_data", data_out, 8'h7E);
    idle(2);
`endif

    // Back-pressure: 12 stalled cycles, 6 pairs offered, 6th dropped
    if (m_phase) idle(1);
    for (int i = 0; i < 12; i++) begin
      if (!m_phase) cyc(1'b1, 8'(8'h80 + i), 1'b1, 8'(8'h81 + i), 1'b0);
      else          cyc(1'b0, '0, 1'b0, '0, 1'b0);
    end
    check("bp_overflow", overflow, 1'b1);
    check("bp_in_ready", in_ready, 1'b0);
    check("bp_hold_data", data_out, 8'h80);
    check("bp_hold_valid", valid_out, 1'b1);
    idle(14);
    check("bp_drained", valid_out, 1'b0);

    // Inputs asserted only on phase-1 edges are ignored
    for (int i = 0; i < 8; i++) begin
      if (m_phase) cyc(1'b1, 8'hFF, 1'b0, '0, 1'b1);
      else         cyc(1'b0, '0, 1'b0, '0, 1'b1);
      check("ph1_ignored", valid_out, 1'b0);
    end

    // Reset during SEND0 with two pairs queued
    offer(1'b1, 8'h10, 1'b1, 8'h20, 1'b0);
    offer(1'b1, 8'h30, 1'b1, 8'h40, 1'b0);
    offer(1'b1, 8'h50, 1'b1, 8'h60, 1'b0);
    reset = 1'b1;
    #1;
    model_reset();
    check("mrst_valid_out", valid_out, 1'b0);
    check("mrst_data_out", data_out, 8'h00);
    check("mrst_in_ready", in_ready, 1'b1);
    check("mrst_overflow", overflow, 1'b0);
    check("mrst_phase", phase, 1'b0);
    @(negedge cclk);
    reset = 1'b0;
    idle(3);
    offer(1'b1, 8'h5A, 1'b1, 8'hC3, 1'b1);
    idle(1);
    check("mrst_first_new", data_out, 8'h5A);
    idle(3);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 1)), 8'($urandom),
          1'($urandom_range(0, 1)), 8'($urandom),
          1'($urandom_range(0, 3) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
